// File: rtl/config_pkg.sv
// Shared types and field layout for the serial configuration receiver.
package config_pkg;

    localparam int CFG_WIDTH = 58;

    // Engine configuration field layout inside the committed word
    localparam int CR_OFFSET_LSB  = 0;
    localparam int CR_OFFSET_MSB  = 15;
    localparam int CI_OFFSET_LSB  = 16;
    localparam int CI_OFFSET_MSB  = 31;
    localparam int SCALING_LSB    = 32;
    localparam int SCALING_MSB    = 38;
    localparam int CTR_SELECT_LSB = 39;
    localparam int CTR_SELECT_MSB = 41;
    localparam int MAX_CTR_LSB    = 42;
    localparam int MAX_CTR_MSB    = 57;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        COMMIT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_SHORT = 2'b01,
        ERR_LONG  = 2'b10,
        ERR_BUSY  = 2'b11
    } err_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus previous-sample flop; level and edge flags are registered.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    // level is the previous synchronised sample, so edges compare sync against it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= d;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end

endmodule

// File: rtl/config_receiver.sv
// Serial frame receiver: shifts sen/sclk/sdata frames into a shadow and commits
// only complete, correctly sized frames while the engine is idle.
module config_receiver #(
    parameter int CFG_WIDTH = config_pkg::CFG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sen_in,
    input  logic                 sclk_in,
    input  logic                 sdata_in,
    input  logic                 busy,
    output logic [CFG_WIDTH-1:0] config_out,
    output logic                 start,
    output logic                 cfg_valid,
    output logic [1:0]           err_code
);
    import config_pkg::*;

    localparam int CNT_W = $clog2(CFG_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_WIDTH + 1);

    logic [2:0] lvl, rise, fall;

    // lane 0 = sen, 1 = sdata, 2 = sclk (pin order on ui_in)
    sync_edge_detect u_sync [2:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({sclk_in, sdata_in, sen_in}),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    logic sen_s, sdata_s, sen_rise, sen_fall, sclk_rise;
    assign sen_s     = lvl[0];
    assign sdata_s   = lvl[1];
    assign sen_rise  = rise[0];
    assign sen_fall  = fall[0];
    assign sclk_rise = rise[2];

    logic unused_edges;
    assign unused_edges = ^{rise[1], fall[1], fall[2], lvl[2]};

    state_e               state;
    err_e                 err_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CFG_WIDTH-1:0] shadow;
    logic [2:0]           warm;
    logic                 armed;

    assign err_code = err_q;

    // armed only once sen has been seen low with a filled synchroniser, so a
    // frame already open across reset release is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            err_q      <= ERR_OK;
            bit_cnt    <= '0;
            shadow     <= '0;
            config_out <= '0;
            start      <= 1'b0;
            cfg_valid  <= 1'b0;
            warm       <= '0;
            armed      <= 1'b0;
        end else begin
            start <= 1'b0;
            warm  <= {warm[1:0], 1'b1};
            if (warm[2] && !sen_s)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (sen_rise && armed) begin
                        bit_cnt <= '0;
                        shadow  <= '0;
                        err_q   <= ERR_OK;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sen_fall) begin
                        state <= COMMIT;
                    end else if (sclk_rise && sen_s) begin
                        shadow <= {sdata_s, shadow[CFG_WIDTH-1:1]};
                        if (bit_cnt != CNT_MAX)
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (bit_cnt < CNT_FULL) begin
                        err_q <= ERR_SHORT;
                    end else if (bit_cnt > CNT_FULL) begin
                        err_q <= ERR_LONG;
                    end else if (busy) begin
                        err_q <= ERR_BUSY;
                    end else begin
                        config_out <= shadow;
                        start      <= 1'b1;
                        cfg_valid  <= 1'b1;
                        err_q      <= ERR_OK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/config_receiver.md
# config_receiver

Serial configuration receiver between the RP2040 pins (ui_in[0] = sen, ui_in[1] = sdata, ui_in[2] = sclk) and the mandelbrot engine. It synchronises the three asynchronous lines and shifts a frame into a private shadow register. Only a complete, correctly sized frame received while the engine is idle is committed to `config_out`, with a one-cycle `start` pulse. Partial, overlong or mistimed frames never reach the engine and are reported through `err_code`.

## Interface
- `CFG_WIDTH`, default 58: frame length in bits; equals the engine configuration width.
- `clk` input, 1: system clock; every register is on its rising edge.
- `rst_n` input, 1: reset. One clock; reset is asynchronous and active-low.
- `sen_in` input, 1: frame enable, asynchronous. High opens a frame; falling edge closes it.
- `sclk_in` input, 1: serial clock, asynchronous. Data is captured on its rising edge.
- `sdata_in` input, 1: serial data, asynchronous.
- `busy` input, 1: the engine or framebuffer is rendering. Commits are refused while it is high.
- `config_out` output, CFG_WIDTH: committed configuration. Reset value 0.
- `start` output, 1: one-cycle pulse in the commit cycle. Reset value 0.
- `cfg_valid` output, 1: set by the first successful commit. Cleared only by reset.
- `err_code` output, 2: status of the last frame. 00 ok, 01 short, 10 long, 11 busy. Reset value 00.

## Operation
- **Synchronisation.** Each input passes through a 2-flop synchroniser, giving the levels `sen_s`, `sclk_s` and `sdata_s`.
  - A third flop holds the previous synchronised sample.
  - An edge is a 0→1 or 1→0 difference between the synchronised sample and the previous one.
  - All synchroniser flops reset to 0.
- **State IDLE.** On a rising edge of `sen_s`: clear `bit_cnt` and the shadow register, set `err_code` = 00, go to SHIFT.
- **State SHIFT.**
  - On a rising edge of `sclk_s` while `sen_s` = 1: `shadow <= {sdata_s, shadow[CFG_WIDTH-1:1]}`. The first bit sent ends up in bit 0 and the last in bit CFG_WIDTH-1.
  - `bit_cnt` is ceil(log2(CFG_WIDTH+2)) bits wide and increments, saturating at CFG_WIDTH+1.
  - Bits beyond CFG_WIDTH still shift (the shadow is discarded anyway); only the count matters.
  - On a falling edge of `sen_s`: go to COMMIT.
- **State COMMIT.** Lasts one cycle, then returns to IDLE. Checks are applied in this priority order:
  1. `bit_cnt` < CFG_WIDTH: `err_code` = 01.
  2. `bit_cnt` > CFG_WIDTH: `err_code` = 10.
  3. `busy` = 1: `err_code` = 11.
  4. Otherwise: `config_out <= shadow`, `start` = 1, `cfg_valid` = 1, `err_code` = 00.
- On every error path, `config_out` keeps its previous value and no `start` is issued.
- `err_code` holds its value until the next rising edge of `sen_s`.
- **Simultaneous events.** An `sclk_s` rising edge in the same cycle as a `sen_s` falling edge is ignored, because `sen_s` is already 0.
- **Sampling rule.** `busy` is sampled only in COMMIT. A `busy` rising in the same cycle still refuses the commit.
- **Reset.** Reset asserted at any point, including mid-frame, forces IDLE and the reset values. The frame is lost and no `start` is issued.
  - After release, a frame whose `sen` is already high is ignored until `sen` goes low and then high again.

## Timing
- Let E0 be the clock edge that first samples a pin change.
  - The synchronised level changes at E2.
  - The FSM reacts at E3.
  - For a `sen` fall, the commit is registered at E4: `start` and the new `config_out` are visible from E4 to E5.
- `config_out` changes only in the same cycle as `start`.
- Minimum serial timing: `sclk` high ≥ 3 clk periods and low ≥ 3 clk periods.
- `sdata` must be stable from 3 clk before the `sclk` rise until 1 clk after it.
- `sen` must fall ≥ 3 clk after the last `sclk` rise.
- Consecutive frames need `sen` low for ≥ 3 clk.

## Structure
- **Package `config_pkg`** holds:
  - `CFG_WIDTH` = 58.
  - Field offsets: CR_OFFSET [15:0], CI_OFFSET [31:16], SCALING [38:32], CTR_SELECT [41:39], MAX_CTR [57:42].
  - The state enum IDLE/SHIFT/COMMIT.
  - The `err_code` enum ERR_OK/ERR_SHORT/ERR_LONG/ERR_BUSY.
- **Sub-module `sync_edge_detect`** (2-flop synchroniser, previous-sample flop, `level`/`rise`/`fall` outputs), instantiated three times.

## Test plan
- **Good frame.** Reset, send 58 bits with `busy` = 0, value 0x2A5_5A5A_1234_8000 (bit 0 first), then drop `sen` → exactly one `start` pulse 4 clk after the sampled `sen` fall. `config_out` = 0x2A5_5A5A_1234_8000, `cfg_valid` = 1, `err_code` = 00.
- **Short frame.** After the good frame, send 57 bits of all ones → `err_code` = 01, no `start`, `config_out` unchanged.
- **Long frame.** Send 59 bits → `err_code` = 10, no `start`, `config_out` unchanged.
- **Busy.** Send a good 58-bit frame while `busy` = 1 at commit → `err_code` = 11, no `start`. Repeat with `busy` = 0 → commit succeeds and `err_code` returns to 00.
- **Reset mid-frame.** Assert `rst_n` = 0 after 30 bits → `config_out` = 0, `cfg_valid` = 0, `err_code` = 00, state IDLE, no `start`. Keep `sen` high through release → no activity until a new `sen` low→high.
- **Edge collision.** Make the last `sclk` rise and the `sen` fall coincide at the pins → that `sclk` edge is not counted, so `bit_cnt` = 57 and `err_code` = 01.
